// File: rtl/pwm_setting_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_setting_ctrl
// Description : Push-button front end for the PWM frequency divider.
//               Each of four raw buttons is synchronized, debounced and
//               edge-detected into a one-cycle press pulse. Press pulses
//               step the saturating frequency code bf (0..BF_MAX) and duty
//               code bc (0..BC_MAX). upd strobes one cycle after a change.
//               Optional macro PWM_SETTING_AUTOREPEAT_EN adds hold-to-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_setting_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int BF_MAX          = 8,
    parameter int BC_MAX          = 10,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 20000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_f_up,
    input  logic       btn_f_dn,
    input  logic       btn_c_up,
    input  logic       btn_c_dn,
    output logic [3:0] bf,
    output logic [3:0] bc,
    output logic       upd
);

    localparam int               c_DEB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       c_BF_MAX   = 4'(BF_MAX);
    localparam logic [3:0]       c_BC_MAX   = 4'(BC_MAX);

`ifdef PWM_SETTING_AUTOREPEAT_EN
    localparam int               c_REP_W     = $clog2((HOLD_CYCLES > REPEAT_CYCLES) ?
                                                      HOLD_CYCLES : REPEAT_CYCLES);
    localparam logic [c_REP_W-1:0] c_HOLD_LAST = c_REP_W'(HOLD_CYCLES - 1);
    localparam logic [c_REP_W-1:0] c_REP_LAST  = c_REP_W'(REPEAT_CYCLES - 1);
`endif

    // Bit order: 0 = f_up, 1 = f_dn, 2 = c_up, 3 = c_dn
    logic [3:0] w_btn_raw;
    logic [3:0] w_press;

    assign w_btn_raw = {btn_c_dn, btn_c_up, btn_f_dn, btn_f_up};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic [1:0]         r_sync;
        logic               r_db;
        logic               r_db_d;
        logic               r_press;
        logic [c_DEB_W-1:0] r_deb_cnt;
        logic               w_rise;
        logic               w_step;

        // Two-flop synchronizer for the asynchronous button level
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync <= 2'b00;
            end else begin
                r_sync <= {r_sync[0], w_btn_raw[i]};
            end
        end

        // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples
        always_ff @(posedge clk) begin
            if (rst) begin
                r_db      <= 1'b0;
                r_deb_cnt <= '0;
            end else if (r_sync[1] == r_db) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == c_DEB_LAST) begin
                r_db      <= r_sync[1];
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end

        assign w_rise = r_db & ~r_db_d;

`ifdef PWM_SETTING_AUTOREPEAT_EN
        logic               r_phase;
        logic               r_rep;
        logic [c_REP_W-1:0] r_hold_cnt;

        // Hold timer: first repeat after HOLD_CYCLES, then every REPEAT_CYCLES
        always_ff @(posedge clk) begin
            if (rst || !r_db) begin
                r_phase    <= 1'b0;
                r_rep      <= 1'b0;
                r_hold_cnt <= '0;
            end else begin
                r_rep <= 1'b0;
                if (!r_phase && (r_hold_cnt == c_HOLD_LAST)) begin
                    r_rep      <= 1'b1;
                    r_phase    <= 1'b1;
                    r_hold_cnt <= '0;
                end else if (r_phase && (r_hold_cnt == c_REP_LAST)) begin
                    r_rep      <= 1'b1;
                    r_hold_cnt <= '0;
                end else begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end
            end
        end

        assign w_step = w_rise | r_rep;
`else
        assign w_step = w_rise;
`endif

        // Edge detector and registered press pulse
        always_ff @(posedge clk) begin
            if (rst) begin
                r_db_d  <= 1'b0;
                r_press <= 1'b0;
            end else begin
                r_db_d  <= r_db;
                r_press <= w_step;
            end
        end

        assign w_press[i] = r_press;
    end

    logic [3:0] r_bf;
    logic [3:0] r_bc;
    logic       r_chg;
    logic       r_upd;
    logic [3:0] w_bf_nxt;
    logic [3:0] w_bc_nxt;

    // Saturating up/down steps; opposing presses in one cycle cancel
    always_comb begin
        w_bf_nxt = r_bf;
        w_bc_nxt = r_bc;
        if (w_press[0] && !w_press[1] && (r_bf != c_BF_MAX)) begin
            w_bf_nxt = r_bf + 4'd1;
        end else if (w_press[1] && !w_press[0] && (r_bf != 4'd0)) begin
            w_bf_nxt = r_bf - 4'd1;
        end
        if (w_press[2] && !w_press[3] && (r_bc != c_BC_MAX)) begin
            w_bc_nxt = r_bc + 4'd1;
        end else if (w_press[3] && !w_press[2] && (r_bc != 4'd0)) begin
            w_bc_nxt = r_bc - 4'd1;
        end
    end

    // Setting registers; upd trails the value change by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bf  <= 4'd0;
            r_bc  <= 4'd0;
            r_chg <= 1'b0;
            r_upd <= 1'b0;
        end else begin
            r_bf  <= w_bf_nxt;
            r_bc  <= w_bc_nxt;
            r_chg <= (w_bf_nxt != r_bf) || (w_bc_nxt != r_bc);
            r_upd <= r_chg;
        end
    end

    assign bf  = r_bf;
    assign bc  = r_bc;
    assign upd = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_pwm_setting_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_setting_ctrl
// Description : Directed, table-driven bench for pwm_setting_ctrl with
//               DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_setting_ctrl;

    localparam int c_DEB  = 4;
    localparam int c_HOLD = 20;
    localparam int c_REP  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;   // {c_dn, c_up, f_dn, f_up}
    logic [3:0] bf;
    logic [3:0] bc;
    logic       upd;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] btn;
        int         hi;
        int         lo;
        int         bf;
        int         bc;
        int         nupd;
    } vec_t;

    vec_t vt[$];

    pwm_setting_ctrl #(
        .DEBOUNCE_CYCLES(c_DEB),
        .BF_MAX        (8),
        .BC_MAX        (10),
        .HOLD_CYCLES   (c_HOLD),
        .REPEAT_CYCLES (c_REP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_f_up(btn[0]),
        .btn_f_dn(btn[1]),
        .btn_c_up(btn[2]),
        .btn_c_dn(btn[3]),
        .bf      (bf),
        .bc      (bc),
        .upd     (upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] b, input int hi, input int lo,
                           input int ebf, input int ebc, input int nupd);
        vec_t v;
        v.btn = b; v.hi = hi; v.lo = lo; v.bf = ebf; v.bc = ebc; v.nupd = nupd;
        vt.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Expected bf k edges after a long f_up hold starts (release after edge 49)
    function automatic int exp_hold_bf(input int k);
        int e = 0;
        if (k >= 7)  e++;
`ifdef PWM_SETTING_AUTOREPEAT_EN
        if (k >= 27) e++;
        if (k >= 35) e++;
        if (k >= 43) e++;
        if (k >= 51) e++;
`endif
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int bfv;
        int bcv;

        // ---------------- reset values ----------------
        do_reset();
        check("reset bf", bf, 0);
        check("reset bc", bc, 0);
        check("reset upd", upd, 0);

        // ---------------- exact press latency ----------------
        btn = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 6) check("lat bf before", bf, 0);
            if (k == 7) begin
                check("lat bf at 7", bf, 1);
                check("lat upd at 7", upd, 0);
            end
            if (k == 8) begin
                check("lat upd at 8", upd, 1);
                check("lat bc", bc, 0);
            end
            if (k == 9) check("lat upd at 9", upd, 0);
        end
        btn = 4'b0000;
        repeat (12) @(negedge clk);
        check("lat bf after release", bf, 1);

        // ---------------- vector table ----------------
        for (int i = 0; i < 5; i++) add_vec(4'b0100, 3, 5, 0, 0, 0);
        for (int i = 1; i <= 12; i++) add_vec(4'b0100, 8, 10, 0, (i > 10) ? 10 : i, (i > 10) ? 0 : 1);
        for (int i = 0; i < 3; i++) add_vec(4'b0010, 8, 10, 0, 10, 0);
        for (int i = 1; i <= 9; i++) add_vec(4'b0001, 8, 10, (i > 8) ? 8 : i, 10, (i > 8) ? 0 : 1);
        for (int i = 7; i >= 4; i--) add_vec(4'b0010, 8, 10, i, 10, 1);
        for (int i = 9; i >= 2; i--) add_vec(4'b1000, 8, 10, 4, i, 1);
        add_vec(4'b0011, 8, 10, 4, 2, 0);
        add_vec(4'b0111, 8, 10, 4, 3, 1);
        add_vec(4'b1111, 8, 10, 4, 3, 0);
        add_vec(4'b1010, 8, 10, 3, 2, 1);

        do_reset();
        foreach (vt[i]) begin
            n = 0;
            for (int c = 0; c < vt[i].hi + vt[i].lo; c++) begin
                btn = (c < vt[i].hi) ? vt[i].btn : 4'b0000;
                @(negedge clk);
                if (upd) n++;
            end
            bfv = int'(bf);
            bcv = int'(bc);
            check($sformatf("vec%0d bf", i), bfv, vt[i].bf);
            check($sformatf("vec%0d bc", i), bcv, vt[i].bc);
            check($sformatf("vec%0d upd count", i), n, vt[i].nupd);
        end

        // ---------------- long hold (auto-repeat when enabled) ----------------
        do_reset();
        n = 0;
        btn = 4'b0001;
        for (int k = 0; k <= 70; k++) begin
            @(negedge clk);
            if (upd) n++;
            if (k == 6 || k == 7 || k == 26 || k == 27 || k == 34 || k == 35 || k == 70)
                check($sformatf("hold bf at edge %0d", k), bf, exp_hold_bf(k));
            if (k == 49) btn = 4'b0000;
        end
`ifdef PWM_SETTING_AUTOREPEAT_EN
        check("hold upd count", n, 5);
`else
        check("hold upd count", n, 1);
`endif

        // ---------------- reset during debounce ----------------
        do_reset();
        btn = 4'b0001;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        btn = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (upd) n++;
        end
        check("rst mid-debounce bf", bf, 0);
        check("rst mid-debounce upd count", n, 0);

        // ---------------- held through reset counts as fresh press ----------------
        btn = 4'b0001;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (upd) n++;
            if (k == 6) check("fresh press bf before", bf, 0);
            if (k == 7) check("fresh press bf at 7", bf, 1);
        end
        check("fresh press upd count", n, 1);
        btn = 4'b0000;
        repeat (12) @(negedge clk);
        check("fresh press bf final", bf, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_setting_ctrl.md
# pwm_setting_ctrl

User-input front end for the PWM frequency divider. Synchronizes and debounces four raw push buttons, then converts presses into the frequency-select code `bf` (0–8) and the duty-select code `bc` (0–10) that drive the divider. All outputs are registered and are held stable between presses. A one-cycle `upd` strobe flags every change.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: cycles a synchronized level must stay stable before it is accepted (≥2).
- `BF_MAX`, default 8: upper saturation value of `bf`.
- `BC_MAX`, default 10: upper saturation value of `bc`. At this value the divider holds its output high.
- `HOLD_CYCLES`, default 50000000: hold time before auto-repeat starts. Used only with `AUTOREPEAT_EN`.
- `REPEAT_CYCLES`, default 20000000: period between auto-repeat steps. Used only with `AUTOREPEAT_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_f_up`  in  1  raw asynchronous button, increments `bf`.
- `btn_f_dn`  in  1  raw asynchronous button, decrements `bf`.
- `btn_c_up`  in  1  raw asynchronous button, increments `bc`.
- `btn_c_dn`  in  1  raw asynchronous button, decrements `bc`.
- `bf`  out  4  frequency select. 0 selects the default 22.5 kHz; 1–8 select 30–200 kHz.
- `bc`  out  4  duty select. 0 selects the nominal divisor; 1–9 select 10–90 %; 10 selects 100 %.
- `upd`  out  1  one-cycle pulse in the cycle after `bf` or `bc` changes value.

## Operation
- Per-button pipeline: 2-flop synchronizer, then debouncer, then rising-edge detector, which produces a one-cycle press pulse.
- Debouncer:
  - Holds an accepted state `db` and a counter.
  - The counter clears whenever the synchronized input equals `db`.
  - When the input differs from `db`, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while the input still differs, `db` takes the input value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles is ignored.
- A press is a 0→1 transition of `db`. Releases generate nothing.
- `bf` counter:
  - An up pulse sets `bf = min(bf+1, BF_MAX)`.
  - A down pulse sets `bf = max(bf-1, 0)`.
  - Both pulses in the same cycle leave `bf` unchanged.
  - The counter saturates; it never wraps.
- `bc` counter: same rules as `bf`, with `BC_MAX` as the upper limit.
- The `bf` and `bc` paths are independent. Simultaneous events on both update both in the same cycle.
- `upd` is asserted for exactly one cycle after any cycle in which `bf` or `bc` changed. It is not asserted for a saturated press that causes no change.
- Arithmetic: 4-bit unsigned. Debounce and repeat counters are sized with `$clog2` of their parameter.

## Timing
- Reset values:
  - `bf=0`, `bc=0`, `upd=0`.
  - All synchronizers, `db` states, debounce counters and repeat counters are cleared.
- Latency: a raw rising edge held stable reaches `bf`/`bc` exactly `DEBOUNCE_CYCLES+3` rising clock edges after it is first sampled. `upd` follows one cycle later.
- Asserting `rst` mid-debounce or mid-hold discards the pending event. A button still held after reset deasserts counts as a fresh press once it has been debounced.
- One step per accepted press, no matter how long the button is held (without `AUTOREPEAT_EN`).

## Configuration
- `PWM_SETTING_AUTOREPEAT_EN` defined:
  - Each `up`/`dn` button has a hold counter that runs while `db=1`.
  - After the initial press step, once the button has been held `HOLD_CYCLES`, the block issues one additional press pulse.
  - It then issues a further pulse every `REPEAT_CYCLES` until release.
  - Saturation rules apply to repeat pulses.
  - Releasing the button clears its hold counter.
- Not defined: no hold or repeat logic is generated, and `HOLD_CYCLES`/`REPEAT_CYCLES` are unused.

## Test plan
Bench settings: `DEBOUNCE_CYCLES=4`, and with the macro defined, `HOLD_CYCLES=20`, `REPEAT_CYCLES=8`.
1. Reset, then hold `btn_f_up` high for 10 cycles → `bf` 0→1 exactly 7 edges after the first sample, `upd` high 1 cycle, `bc` stays 0.
2. Give 3-cycle high glitches on `btn_c_up`, repeated 5 times with 5 low cycles between → `bc` stays 0 and `upd` never asserts.
3. Give 12 clean `btn_c_up` presses → `bc` sequence 1..10, then stays 10. No `upd` on the last two presses.
4. Give 3 clean `btn_f_dn` presses from `bf=0` → `bf` stays 0. Then 9 `btn_f_up` presses → `bf` saturates at 8.
5. Assert debounced presses of `btn_f_up` and `btn_f_dn` in the same cycle with `bf=4` → `bf` stays 4 and `upd=0`. In the same cycle press `btn_c_up` with `bc=2` → `bc=3`.
6. Assert `rst` 2 cycles into a `btn_f_up` debounce → no step. With the macro defined, from `bf=0` hold `btn_f_up` for 50 cycles → `bf=1`, then `bf=2` 20 cycles after acceptance, then +1 every 8 cycles until release.
